acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised successor of the 8-bit accumulator CPU.
- Data width and address width are generic.
- Instruction fetch and RAM data access use one shared bus with a req/ack handshake, so wait states are supported.
- Adds STORE, conditional jump and HALT.
- Sits between the ROM/RAM arbiter and the top-level debug pins.

Parameters:
- BITS, 8, data/accumulator/register width; must be >= 8.
- ADDR_BITS, 8, PC and bus address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- bus_req  output  1  transfer request.
- bus_ack  input  1  transfer completes on a clk edge where bus_req && bus_ack.
- bus_rom_ram  output  1  0 = ROM (instruction fetch), 1 = RAM (data).
- bus_we  output  1  1 = write (STORE only).
- bus_addr  output  ADDR_BITS  transfer address.
- bus_wdata  output  BITS  store data.
- bus_rdata  input  BITS  read data; sampled on the completing edge.
- acc_out  output  BITS  accumulator (debug).
- halted  output  1  core stopped.
- illegal  output  1  sticky; set when halted by an undefined opcode.

Behaviour:
- Reset (reset low, async):
  - pc=0, acc=0, all registers r0..r7=0, state=FETCH.
  - bus_req=0, bus_we=0, halted=0, illegal=0.
  - Reset during a pending transfer drops bus_req immediately; nothing is retired.
- Instruction byte is bus_rdata[7:0]: opcode=[7:3], field f=[2:0] (immediate or register index).
- There are always 8 registers.
- States:
  - FETCH: bus_req=1, rom_ram=0, we=0, addr=pc. On ack: latch instr, go to EXEC.
  - EXEC: one cycle. ALU/jump ops retire here, pc advances, go to FETCH. LOAD/STORE go to MEM. HALT or illegal goes to HALT.
  - MEM: bus_req=1, rom_ram=1, addr=r[f][ADDR_BITS-1:0] (zero-extended if BITS<ADDR_BITS). STORE drives we=1, wdata=acc. On ack: LOAD writes acc<=bus_rdata, pc advances, go to FETCH.
  - HALT: terminal; halted=1, bus_req=0. Left only by reset.
- Handshake:
  - bus_addr, bus_we, bus_rom_ram and bus_wdata are stable from bus_req rise until the completing edge.
  - bus_req deasserts in the cycle after completion (EXEC never requests).
  - Any number of wait cycles is allowed.
  - ack while bus_req=0 is ignored.
- Latency with zero-wait ack:
  - ALU instruction = 2 cycles.
  - LOAD/STORE = 3 cycles.
- Opcodes (imm zero-extended; arithmetic modulo 2^BITS):
  - 00 NOP
  - 01 LDI acc=imm
  - 02 ADDI acc+=imm
  - 03 ADD acc+=r[f]
  - 04 SUB acc-=r[f]
  - 05 AND
  - 06 OR
  - 07 XOR (05-07 use r[f])
  - 08 GETACC r[f]=acc
  - 09 SETACC acc=r[f]
  - 0A LOAD
  - 0B STORE
  - 0C JZ: if acc==0, pc=r[f][ADDR_BITS-1:0], else pc+1
  - 0D SHL acc<<=imm
  - 1F HALT
  - All others: illegal=1, go to HALT, pc not advanced.
- pc increments modulo 2^ADDR_BITS; 0xFF+1 wraps to 0x00 at the default width.
- JZ to its own address is a legal infinite loop.
- The register file has one write port and one read port. Writes occur only in EXEC (GETACC). Reads are combinational from f.
- acc_out always reflects the acc register.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_*;
  - state encoding (FETCH/EXEC/MEM/HALT, 2 bits);
  - field widths (OPC_BITS=5, F_BITS=3).
- One sub-module, cpu_regfile: parametrised on BITS, 8 entries, async reset, 1W/1R.
- Control FSM and ALU stay in acc_cpu_core.

Test Plan:
- Zero-wait ALU program, ROM = LDI 5; ADDI 3; GETACC r1; ADD r1; HALT:
  - acc_out = 16;
  - halted rises on the 10th edge after reset release;
  - pc = 4.
- Wait states, ack delayed 3 cycles on every transfer:
  - addr/req stable throughout;
  - same final acc=16;
  - exactly one instruction retired per completed fetch.
- Memory round trip: LDI 7; GETACC r2; LDI 2; STORE r2; LDI 0; LOAD r2:
  - RAM[7] written with 0x02 and we=1 only in the MEM cycle;
  - final acc=0x02.
- Branch and wrap:
  - JZ with acc=0 and r3=0x40 → next fetch addr 0x40.
  - JZ with acc≠0 → pc+1.
  - NOP at 0xFF → next fetch 0x00.
- Illegal opcode 0x10:
  - halted=1, illegal=1, bus_req stays 0, pc unchanged.
- Async reset asserted mid-MEM wait with ack withheld:
  - bus_req falls without a clock edge;
  - all outputs return to reset values;
  - after release, first fetch is from addr 0.
- BITS=16, ADDR_BITS=10 build: ADDI to 0xFFFF wraps to 0x0002 (0xFFFF+3); pc wraps at 0x3FF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator CPU:
// instruction field widths, opcode values and the control FSM state encoding.
package cpu_pkg;

    localparam int OPC_BITS = 5;
    localparam int F_BITS   = 3;
    localparam int NUM_REGS = 1 << F_BITS;

    localparam logic [OPC_BITS-1:0] OP_NOP    = 5'h00;
    localparam logic [OPC_BITS-1:0] OP_LDI    = 5'h01;
    localparam logic [OPC_BITS-1:0] OP_ADDI   = 5'h02;
    localparam logic [OPC_BITS-1:0] OP_ADD    = 5'h03;
    localparam logic [OPC_BITS-1:0] OP_SUB    = 5'h04;
    localparam logic [OPC_BITS-1:0] OP_AND    = 5'h05;
    localparam logic [OPC_BITS-1:0] OP_OR     = 5'h06;
    localparam logic [OPC_BITS-1:0] OP_XOR    = 5'h07;
    localparam logic [OPC_BITS-1:0] OP_GETACC = 5'h08;
    localparam logic [OPC_BITS-1:0] OP_SETACC = 5'h09;
    localparam logic [OPC_BITS-1:0] OP_LOAD   = 5'h0A;
    localparam logic [OPC_BITS-1:0] OP_STORE  = 5'h0B;
    localparam logic [OPC_BITS-1:0] OP_JZ     = 5'h0C;
    localparam logic [OPC_BITS-1:0] OP_SHL    = 5'h0D;
    localparam logic [OPC_BITS-1:0] OP_HALT   = 5'h1F;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Instruction byte layout: opcode in [7:3], immediate / register index in [2:0].
    typedef struct packed {
        logic [OPC_BITS-1:0] opcode;
        logic [F_BITS-1:0]   f;
    } instr_t;

endpackage

// File: rtl/cpu_regfile.sv
// Eight-entry general register file: one synchronous write port, one combinational read port.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [F_BITS-1:0] waddr,
    input  logic [BITS-1:0]   wdata,
    input  logic [F_BITS-1:0] raddr,
    output logic [BITS-1:0]   rdata
);

    logic [BITS-1:0] regs [NUM_REGS];

    // NOTE: an array this small is plain flops, so clearing every entry on reset is cheap;
    // a large RAM would be left unreset so it can still map onto a memory macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU: FETCH/EXEC/MEM/HALT control FSM and ALU,
// sharing one req/ack bus between instruction fetch and RAM data access.
module acc_cpu_core
    import cpu_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 bus_req,
    input  logic                 bus_ack,
    output logic                 bus_rom_ram,
    output logic                 bus_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [BITS-1:0]      bus_wdata,
    input  logic [BITS-1:0]      bus_rdata,
    output logic [BITS-1:0]      acc_out,
    output logic                 halted,
    output logic                 illegal
);

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] pc, pc_next;
    logic [BITS-1:0]      acc, acc_next;
    instr_t               instr, instr_next;
    logic                 illegal_q, illegal_next;

    logic                 rf_we;
    logic [BITS-1:0]      rf_rdata;
    logic [BITS-1:0]      imm;
    logic [ADDR_BITS-1:0] pc_inc;
    logic [ADDR_BITS-1:0] reg_addr;
    logic                 xfer_done;

    cpu_regfile #(.BITS(BITS)) u_regfile (
        .clk   (clk),
        .rst_n (reset),
        .we    (rf_we),
        .waddr (instr.f),
        .wdata (acc),
        .raddr (instr.f),
        .rdata (rf_rdata)
    );

    assign imm       = BITS'(instr.f);
    assign pc_inc    = pc + ADDR_BITS'(1);
    assign reg_addr  = ADDR_BITS'(rf_rdata);
    assign xfer_done = bus_req && bus_ack;

    // Gating with reset drops a pending request the instant reset asserts, without waiting for a clock.
    assign bus_req     = reset && ((state == FETCH) || (state == MEM));
    assign bus_rom_ram = (state == MEM);
    assign bus_we      = (state == MEM) && (instr.opcode == OP_STORE);
    assign bus_addr    = (state == MEM) ? reg_addr : pc;
    assign bus_wdata   = acc;
    assign acc_out     = acc;
    assign halted      = (state == HALT);
    assign illegal     = illegal_q;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        acc_next     = acc;
        instr_next   = instr;
        illegal_next = illegal_q;
        rf_we        = 1'b0;

        case (state)
            FETCH: begin
                if (xfer_done) begin
                    instr_next = instr_t'(bus_rdata[7:0]);
                    state_next = EXEC;
                end
            end

            EXEC: begin
                state_next = FETCH;
                pc_next    = pc_inc;
                case (instr.opcode)
                    OP_NOP:    ;
                    OP_LDI:    acc_next = imm;
                    OP_ADDI:   acc_next = acc + imm;
                    OP_ADD:    acc_next = acc + rf_rdata;
                    OP_SUB:    acc_next = acc - rf_rdata;
                    OP_AND:    acc_next = acc & rf_rdata;
                    OP_OR:     acc_next = acc | rf_rdata;
                    OP_XOR:    acc_next = acc ^ rf_rdata;
                    OP_GETACC: rf_we    = 1'b1;
                    OP_SETACC: acc_next = rf_rdata;
                    OP_LOAD, OP_STORE: begin
                        pc_next    = pc;
                        state_next = MEM;
                    end
                    OP_JZ: begin
                        if (acc == '0) begin
                            pc_next = reg_addr;
                        end
                    end
                    OP_SHL:    acc_next = acc << instr.f;
                    OP_HALT: begin
                        pc_next    = pc;
                        state_next = HALT;
                    end
                    default: begin
                        pc_next      = pc;
                        illegal_next = 1'b1;
                        state_next   = HALT;
                    end
                endcase
            end

            MEM: begin
                if (xfer_done) begin
                    if (instr.opcode == OP_LOAD) begin
                        acc_next = bus_rdata;
                    end
                    pc_next    = pc_inc;
                    state_next = FETCH;
                end
            end

            HALT: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc        <= '0;
            acc       <= '0;
            instr     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            acc       <= acc_next;
            instr     <= instr_next;
            illegal_q <= illegal_next;
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: a default 8/8 build behind a wait-state ROM/RAM model,
// and a 16/10 build checking wide arithmetic and pc wrap.
module tb_acc_cpu_core;

    localparam int BITS   = 8;
    localparam int ABITS  = 8;
    localparam int WBITS  = 16;
    localparam int WABITS = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default build
    logic              reset = 1'b0;
    logic              bus_req;
    logic              bus_ack = 1'b0;
    logic              bus_rom_ram;
    logic              bus_we;
    logic [ABITS-1:0]  bus_addr;
    logic [BITS-1:0]   bus_wdata;
    logic [BITS-1:0]   bus_rdata = '0;
    logic [BITS-1:0]   acc_out;
    logic              halted;
    logic              illegal;

    // wide build
    logic              reset16 = 1'b0;
    logic              bus_req16;
    logic              bus_ack16 = 1'b0;
    logic              bus_rom_ram16;
    logic              bus_we16;
    logic [WABITS-1:0] bus_addr16;
    logic [WBITS-1:0]  bus_wdata16;
    logic [WBITS-1:0]  bus_rdata16 = '0;
    logic [WBITS-1:0]  acc_out16;
    logic              halted16;
    logic              illegal16;

    acc_cpu_core #(.BITS(BITS), .ADDR_BITS(ABITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .bus_rom_ram (bus_rom_ram),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .acc_out     (acc_out),
        .halted      (halted),
        .illegal     (illegal)
    );

    acc_cpu_core #(.BITS(WBITS), .ADDR_BITS(WABITS)) dut16 (
        .clk         (clk),
        .reset       (reset16),
        .bus_req     (bus_req16),
        .bus_ack     (bus_ack16),
        .bus_rom_ram (bus_rom_ram16),
        .bus_we      (bus_we16),
        .bus_addr    (bus_addr16),
        .bus_wdata   (bus_wdata16),
        .bus_rdata   (bus_rdata16),
        .acc_out     (acc_out16),
        .halted      (halted16),
        .illegal     (illegal16)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // ---------------- bus model for the default build ----------------
    logic [7:0]      rom [256];
    logic [BITS-1:0] ram [256];
    int              wait_cfg = 0;
    bit              hold_ram = 1'b0;

    int                      wait_cnt;
    bit                      in_xfer;
    logic [ABITS+BITS+1:0]   cap;
    int                      unstable;
    int                      we_bad;
    int                      we_cycles;
    int                      writes;
    logic [ABITS-1:0]        write_addr;
    logic [ABITS-1:0]        fetch_log [$];

    // Acks are decided on the falling edge; the transfer then completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            bus_ack    = 1'b0;
            bus_rdata  = '0;
            wait_cnt   = 0;
            in_xfer    = 1'b0;
            unstable   = 0;
            we_bad     = 0;
            we_cycles  = 0;
            writes     = 0;
            write_addr = '0;
            fetch_log.delete();
            for (int i = 0; i < 256; i++) ram[i] = '0;
        end else begin
            if (bus_ack) begin
                wait_cnt = 0;
                in_xfer  = 1'b0;
            end
            if (bus_we && !(bus_req && bus_rom_ram)) we_bad++;
            if (bus_we) we_cycles++;
            if (bus_req) begin
                if (!in_xfer) begin
                    cap     = {bus_addr, bus_we, bus_rom_ram, bus_wdata};
                    in_xfer = 1'b1;
                end else if ({bus_addr, bus_we, bus_rom_ram, bus_wdata} !== cap) begin
                    unstable++;
                end
                if (wait_cnt >= wait_cfg && !(bus_rom_ram && hold_ram)) begin
                    bus_ack = 1'b1;
                    if (bus_rom_ram) begin
                        if (bus_we) begin
                            ram[bus_addr] = bus_wdata;
                            writes++;
                            write_addr = bus_addr;
                        end
                        bus_rdata = ram[bus_addr];
                    end else begin
                        bus_rdata = BITS'(rom[bus_addr]);
                        fetch_log.push_back(bus_addr);
                    end
                end else begin
                    bus_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus_ack = 1'b0;
            end
        end
    end

    // ---------------- zero-wait ROM model for the wide build ----------------
    logic [7:0]        rom16 [1024];
    int                fetch16_count;
    logic [WABITS-1:0] fetch16_last;

    always @(negedge clk) begin
        if (!reset16) begin
            bus_ack16     = 1'b0;
            fetch16_count = 0;
            fetch16_last  = '0;
        end else begin
            bus_ack16 = bus_req16;
            if (bus_req16 && !bus_rom_ram16) begin
                bus_rdata16   = WBITS'(rom16[bus_addr16]);
                fetch16_count++;
                fetch16_last  = bus_addr16;
            end
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] alu_prog [5] = '{8'h0D, 8'h13, 8'h41, 8'h19, 8'hF8};
    logic [7:0] mem_prog [7] = '{8'h0F, 8'h42, 8'h0A, 8'h5A, 8'h08, 8'h52, 8'hF8};

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    // Holds reset for a few cycles and releases it mid-high-phase, so edge 1 is the first fetch edge.
    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int edges);
        edges = 0;
        while (!halted && edges < budget) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    initial begin
        int edges;
        int n;

        clear_rom();
        for (int i = 0; i < 1024; i++) rom16[i] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",     32'(bus_req), 32'd0);
        check("rst_we",      32'(bus_we), 32'd0);
        check("rst_halted",  32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_acc",     32'(acc_out), 32'd0);
        check("rst_pc",      32'(dut.pc), 32'd0);

        // zero-wait ALU program: LDI 5; ADDI 3; GETACC r1; ADD r1; HALT
        for (int i = 0; i < 5; i++) rom[i] = alu_prog[i];
        wait_cfg = 0;
        apply_reset();
        run_until_halt(60, edges);
        check("alu_halted",  32'(halted), 32'd1);
        check("alu_edges",   32'(edges), 32'd10);
        check("alu_acc",     32'(acc_out), 32'h10);
        check("alu_pc",      32'(dut.pc), 32'd4);
        check("alu_illegal", 32'(illegal), 32'd0);
        check("alu_fetches", 32'(fetch_log.size()), 32'd5);
        check("alu_req_off", 32'(bus_req), 32'd0);

        // same program with three wait cycles on every transfer
        wait_cfg = 3;
        apply_reset();
        run_until_halt(200, edges);
        check("wait_halted",   32'(halted), 32'd1);
        check("wait_edges",    32'(edges), 32'd25);
        check("wait_acc",      32'(acc_out), 32'h10);
        check("wait_fetches",  32'(fetch_log.size()), 32'd5);
        check("wait_stable",   32'(unstable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i < fetch_log.size()) check($sformatf("wait_fetch_addr%0d", i), 32'(fetch_log[i]), 32'(i));
        end
        wait_cfg = 0;

        // memory round trip: LDI 7; GETACC r2; LDI 2; STORE r2; LDI 0; LOAD r2; HALT
        clear_rom();
        for (int i = 0; i < 7; i++) rom[i] = mem_prog[i];
        apply_reset();
        run_until_halt(100, edges);
        check("mem_halted",     32'(halted), 32'd1);
        check("mem_edges",      32'(edges), 32'd16);
        check("mem_ram7",       32'(ram[7]), 32'h02);
        check("mem_writes",     32'(writes), 32'd1);
        check("mem_write_addr", 32'(write_addr), 32'd7);
        check("mem_we_cycles",  32'(we_cycles), 32'd1);
        check("mem_we_outside", 32'(we_bad), 32'd0);
        check("mem_acc",        32'(acc_out), 32'h02);

        // branches and pc wrap
        clear_rom();
        rom[8'h00] = 8'h09; rom[8'h01] = 8'h6E; rom[8'h02] = 8'h43; rom[8'h03] = 8'h08; rom[8'h04] = 8'h63;
        rom[8'h40] = 8'h09; rom[8'h41] = 8'h63;
        rom[8'h42] = 8'h09; rom[8'h43] = 8'h41; rom[8'h44] = 8'h08; rom[8'h45] = 8'h21;
        rom[8'h46] = 8'h44; rom[8'h47] = 8'h08; rom[8'h48] = 8'h64;
        rom[8'hFF] = 8'h00;
        apply_reset();
        n = 0;
        while (fetch_log.size() < 16 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("br_progress", 32'(fetch_log.size() >= 16), 32'd1);
        if (fetch_log.size() >= 16) begin
            check("br_jz_taken",     32'(fetch_log[5]), 32'h40);
            check("br_jz_not_taken", 32'(fetch_log[7]), 32'h42);
            check("br_jz_to_ff",     32'(fetch_log[14]), 32'hFF);
            check("br_pc_wrap",      32'(fetch_log[15]), 32'h00);
        end

        // illegal opcode 0x10 at address 2
        clear_rom();
        rom[2] = 8'h80;
        apply_reset();
        run_until_halt(60, edges);
        check("ill_halted",  32'(halted), 32'd1);
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_edges",   32'(edges), 32'd6);
        check("ill_pc",      32'(dut.pc), 32'd2);
        repeat (4) @(negedge clk);
        #1;
        check("ill_req_stays_low", 32'(bus_req), 32'd0);
        check("ill_fetches",       32'(fetch_log.size()), 32'd3);

        // async reset while a LOAD waits for an ack that never comes
        clear_rom();
        rom[0] = 8'h0D;
        rom[1] = 8'h50;
        hold_ram = 1'b1;
        apply_reset();
        check("arst_illegal_cleared", 32'(illegal), 32'd0);
        n = 0;
        while (!(bus_req && bus_rom_ram) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("arst_in_mem", 32'(bus_req && bus_rom_ram), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("arst_still_waiting", 32'(bus_req), 32'd1);
        check("arst_acc_before",    32'(acc_out), 32'd5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req",     32'(bus_req), 32'd0);
        check("arst_we",      32'(bus_we), 32'd0);
        check("arst_rom_ram", 32'(bus_rom_ram), 32'd0);
        check("arst_acc",     32'(acc_out), 32'd0);
        check("arst_halted",  32'(halted), 32'd0);
        check("arst_illegal", 32'(illegal), 32'd0);
        check("arst_pc",      32'(dut.pc), 32'd0);
        hold_ram = 1'b0;
        apply_reset();
        n = 0;
        while (fetch_log.size() == 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("arst_refetch", 32'(fetch_log.size() > 0), 32'd1);
        if (fetch_log.size() > 0) check("arst_first_fetch_addr", 32'(fetch_log[0]), 32'd0);
        reset = 1'b0;

        // wide build: LDI 1; GETACC r1; LDI 0; SUB r1; ADDI 3; NOPs up to 0x3FF
        rom16[0] = 8'h09; rom16[1] = 8'h41; rom16[2] = 8'h08; rom16[3] = 8'h21; rom16[4] = 8'h13;
        @(posedge clk);
        #2;
        reset16 = 1'b1;
        n = 0;
        while (fetch16_last !== 10'h004 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("w16_reach_addi", 32'(fetch16_last), 32'h004);
        check("w16_sub_wrap",   32'(acc_out16), 32'hFFFF);
        n = 0;
        while (fetch16_last !== 10'h3FF && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("w16_reach_3ff",  32'(fetch16_last), 32'h3FF);
        check("w16_addi_wrap",  32'(acc_out16), 32'h0002);
        check("w16_illegal",    32'(illegal16), 32'd0);
        check("w16_we",         32'(bus_we16), 32'd0);
        n = fetch16_count;
        for (int k = 0; k < 10 && fetch16_count == n; k++) begin
            @(negedge clk);
            #1;
        end
        check("w16_next_fetch", 32'(fetch16_count), 32'(n + 1));
        check("w16_pc_wrap",    32'(fetch16_last), 32'h000);
        reset16 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
